// File: rtl/audio_adc_rx.sv
// Left-justified ADC serial receiver: deserializes the codec stream into left/right PCM pairs
// on a valid/ready handshake. Define ADC_RX_PEAK_EN to build the peak-magnitude tracker.
module audio_adc_rx #(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  iCLK_18_4,
  input  logic                  iRST_N,
  input  logic                  iAUD_BCK,
  input  logic                  iAUD_ADCLRCK,
  input  logic                  iAUD_ADCDAT,
  output logic [DATA_WIDTH-1:0] oLEFT,
  output logic [DATA_WIDTH-1:0] oRIGHT,
  output logic                  oVALID,
  input  logic                  iREADY,
  output logic                  oOVERRUN,
  input  logic                  iOVR_CLR,
  output logic [DATA_WIDTH-1:0] oPEAK,
  input  logic                  iPEAK_CLR
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {S_HUNT, S_LEFT, S_RIGHT} state_t;

  logic [SYNC_STAGES-1:0] bck_sync, lrck_sync, dat_sync;
  logic                   bck_d, lrck_prev;
  logic                   bck_s, lrck_s, dat_s, bck_rise;

  state_t                 state, state_nxt;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic [DATA_WIDTH-1:0]  left_sr, left_nxt, right_sr, right_nxt;
  logic                   commit, load;

  // All three inputs see the same depth so data and LRCK stay aligned with the BCK edge.
  assign bck_s    = bck_sync[SYNC_STAGES-1];
  assign lrck_s   = lrck_sync[SYNC_STAGES-1];
  assign dat_s    = dat_sync[SYNC_STAGES-1];
  assign bck_rise = bck_s & ~bck_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
    if (!iRST_N) begin
      bck_sync  <= '0;
      lrck_sync <= '0;
      dat_sync  <= '0;
      bck_d     <= 1'b0;
      lrck_prev <= 1'b0;
      state     <= S_HUNT;
      cnt       <= '0;
      left_sr   <= '0;
      right_sr  <= '0;
    end else begin
      bck_sync  <= {bck_sync[SYNC_STAGES-2:0], iAUD_BCK};
      lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], iAUD_ADCLRCK};
      dat_sync  <= {dat_sync[SYNC_STAGES-2:0], iAUD_ADCDAT};
      bck_d     <= bck_s;
      if (bck_rise) lrck_prev <= lrck_s;
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      left_sr   <= left_nxt;
      right_sr  <= right_nxt;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    left_nxt  = left_sr;
    right_nxt = right_sr;
    commit    = 1'b0;
    if (bck_rise) begin
      unique case (state)
        S_HUNT: begin
          if (lrck_s && !lrck_prev) begin
            state_nxt = S_LEFT;
            left_nxt  = {{(DATA_WIDTH-1){1'b0}}, dat_s};
            cnt_nxt   = CW'(1);
          end
        end
        S_LEFT: begin
          if (!lrck_s) begin
            // A short left word cannot be paired; resynchronise on the next frame start.
            if (cnt == FULL) begin
              state_nxt = S_RIGHT;
              right_nxt = {{(DATA_WIDTH-1){1'b0}}, dat_s};
              cnt_nxt   = CW'(1);
            end else begin
              state_nxt = S_HUNT;
              cnt_nxt   = '0;
            end
          end else if (cnt < FULL) begin
            left_nxt = {left_sr[DATA_WIDTH-2:0], dat_s};
            cnt_nxt  = cnt + CW'(1);
          end
        end
        S_RIGHT: begin
          if (lrck_s) begin
            state_nxt = S_LEFT;
            left_nxt  = {{(DATA_WIDTH-1){1'b0}}, dat_s};
            cnt_nxt   = CW'(1);
          end else if (cnt < FULL) begin
            right_nxt = {right_sr[DATA_WIDTH-2:0], dat_s};
            cnt_nxt   = cnt + CW'(1);
            commit    = (cnt == LAST);
          end
        end
        default: begin
          state_nxt = S_HUNT;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign load = commit && (!oVALID || iREADY);

  always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
    if (!iRST_N) begin
      oLEFT    <= '0;
      oRIGHT   <= '0;
      oVALID   <= 1'b0;
      oOVERRUN <= 1'b0;
    end else begin
      if (load) begin
        oLEFT  <= left_sr;
        oRIGHT <= right_nxt;
        oVALID <= 1'b1;
      end else if (oVALID && iREADY) begin
        oVALID <= 1'b0;
      end
      if (commit && oVALID && !iREADY) oOVERRUN <= 1'b1;
      else if (iOVR_CLR)               oOVERRUN <= 1'b0;
    end
  end

`ifdef ADC_RX_PEAK_EN
  // Two's-complement magnitude; the most negative code saturates to the largest positive one.
  function automatic logic [DATA_WIDTH-1:0] mag(input logic [DATA_WIDTH-1:0] w);
    logic [DATA_WIDTH-1:0] n;
    n = ~w + 1'b1;
    if (!w[DATA_WIDTH-1]) return w;
    if (n[DATA_WIDTH-1])  return {1'b0, {(DATA_WIDTH-1){1'b1}}};
    return n;
  endfunction

  logic [DATA_WIDTH-1:0] mag_l, mag_r, peak_upd;

  always_comb begin
    mag_l    = mag(left_sr);
    mag_r    = mag(right_nxt);
    peak_upd = oPEAK;
    if (mag_l > peak_upd) peak_upd = mag_l;
    if (mag_r > peak_upd) peak_upd = mag_r;
  end

  always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
    if (!iRST_N)        oPEAK <= '0;
    else if (iPEAK_CLR) oPEAK <= '0;
    else if (load)      oPEAK <= peak_upd;
  end
`else
  logic unused_peak_clr;
  assign unused_peak_clr = iPEAK_CLR;
  assign oPEAK           = '0;
`endif

endmodule
